// File: rtl/i2c_slave_pkg.sv
// Shared types and constants for the I2C target receiver: FSM states, field
// widths and the address/direction match helper.
package i2c_slave_pkg;

  localparam int unsigned I2C_ADDR_W = 7;
  localparam int unsigned I2C_BYTE_W = 8;
  localparam int unsigned RW_BIT     = 0;
  localparam int unsigned CNT_W      = 11;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    DATA,
    DATA_ACK,
    STRETCH,
    IGNORE
  } state_t;

  // True when the address byte names this target and requests a write (R/W = 0)
  function automatic logic addr_write_match(input logic [I2C_BYTE_W-1:0] b,
                                            input logic [I2C_ADDR_W-1:0] a);
    return (b[I2C_BYTE_W-1 -: I2C_ADDR_W] == a) && (b[RW_BIT] == 1'b0);
  endfunction

endpackage

// File: rtl/i2c_bus_sync.sv
// Synchronizes the SCL/SDA pads and derives single-cycle edge, START and STOP
// strobes from the synchronized levels.
module i2c_bus_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clock,
  input  logic reset,
  input  logic scl_in,
  input  logic sda_in,
  output logic sda,
  output logic scl_rise,
  output logic scl_fall,
  output logic start,
  output logic stop
);

  logic [SYNC_STAGES-1:0] scl_sr;
  logic [SYNC_STAGES-1:0] sda_sr;
  logic                   scl;
  logic                   scl_q;
  logic                   sda_q;

  // Reset to the idle bus level so leaving reset never fakes an edge
  always_ff @(posedge clock) begin
    if (reset) begin
      scl_sr <= '1;
      sda_sr <= '1;
      scl_q  <= 1'b1;
      sda_q  <= 1'b1;
    end else begin
      scl_sr <= {scl_sr[SYNC_STAGES-2:0], scl_in};
      sda_sr <= {sda_sr[SYNC_STAGES-2:0], sda_in};
      scl_q  <= scl;
      sda_q  <= sda;
    end
  end

  assign scl      = scl_sr[SYNC_STAGES-1];
  assign sda      = sda_sr[SYNC_STAGES-1];
  assign scl_rise = scl & ~scl_q;
  assign scl_fall = ~scl & scl_q;
  assign start    = scl & scl_q & sda_q & ~sda;
  assign stop     = scl & scl_q & ~sda_q & sda;

endmodule

// File: rtl/i2c_slave_receiver.sv
// I2C target write-receiver: address match with ACK, data bytes ACKed and
// handed out over valid/ready, SCL stretched while a byte is unconsumed.
module i2c_slave_receiver
  import i2c_slave_pkg::*;
#(
  parameter logic [I2C_ADDR_W-1:0] ADDRESS         = 7'h50,
  parameter int unsigned           SYNC_STAGES     = 2,
  parameter logic [CNT_W-1:0]      STRETCH_TIMEOUT = 11'd2000
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  scl_in,
  input  logic                  sda_in,
  output logic                  scl_oe,
  output logic                  sda_oe,
  output logic [I2C_BYTE_W-1:0] rx_data,
  output logic                  rx_valid,
  input  logic                  rx_ready,
  output logic                  rx_first,
  output logic                  start_seen,
  output logic                  stop_seen,
  output logic                  stretch_timeout,
  output logic                  busy
);

  localparam int unsigned      BIT_W    = $clog2(I2C_BYTE_W + 1);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(I2C_BYTE_W);

  state_t                state;
  logic [BIT_W-1:0]      bitcnt;
  logic [I2C_BYTE_W-1:0] shift;
  logic [CNT_W-1:0]      stretch_cnt;
  logic                  first_pending;
  logic                  sda;
  logic                  scl_rise;
  logic                  scl_fall;
  logic                  start;
  logic                  stop;

  i2c_bus_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clock    (clock),
    .reset    (reset),
    .scl_in   (scl_in),
    .sda_in   (sda_in),
    .sda      (sda),
    .scl_rise (scl_rise),
    .scl_fall (scl_fall),
    .start    (start),
    .stop     (stop)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state           <= IDLE;
      bitcnt          <= '0;
      shift           <= '0;
      stretch_cnt     <= '0;
      first_pending   <= 1'b0;
      scl_oe          <= 1'b0;
      sda_oe          <= 1'b0;
      rx_data         <= '0;
      rx_valid        <= 1'b0;
      rx_first        <= 1'b0;
      start_seen      <= 1'b0;
      stop_seen       <= 1'b0;
      stretch_timeout <= 1'b0;
      busy            <= 1'b0;
    end else begin
      start_seen      <= 1'b0;
      stop_seen       <= 1'b0;
      stretch_timeout <= 1'b0;
      if (rx_valid && rx_ready) rx_valid <= 1'b0;

      // Bus conditions pre-empt any bit edge seen in the same cycle
      if (start) begin
        state      <= ADDR;
        bitcnt     <= '0;
        start_seen <= 1'b1;
        sda_oe     <= 1'b0;
        scl_oe     <= 1'b0;
      end else if (stop) begin
        state     <= IDLE;
        bitcnt    <= '0;
        stop_seen <= 1'b1;
        busy      <= 1'b0;
        sda_oe    <= 1'b0;
        scl_oe    <= 1'b0;
      end else begin
        case (state)
          ADDR, DATA: begin
            if (scl_rise && bitcnt != LAST_BIT) begin
              shift  <= {shift[I2C_BYTE_W-2:0], sda};
              bitcnt <= bitcnt + 1'b1;
            end else if (scl_fall && bitcnt == LAST_BIT) begin
              if (state == DATA) begin
                rx_data       <= shift;
                rx_valid      <= 1'b1;
                rx_first      <= first_pending;
                first_pending <= 1'b0;
                sda_oe        <= 1'b1;
                state         <= DATA_ACK;
              end else if (addr_write_match(shift, ADDRESS)) begin
                sda_oe <= 1'b1;
                busy   <= 1'b1;
                state  <= ADDR_ACK;
              end else begin
                busy  <= 1'b0;
                state <= IGNORE;
              end
            end
          end
          ADDR_ACK: begin
            if (scl_fall) begin
              sda_oe        <= 1'b0;
              bitcnt        <= '0;
              first_pending <= 1'b1;
              state         <= DATA;
            end
          end
          DATA_ACK: begin
            if (scl_fall) begin
              sda_oe <= 1'b0;
              bitcnt <= '0;
              if (rx_valid && !rx_ready) begin
                scl_oe      <= 1'b1;
                stretch_cnt <= '0;
                state       <= STRETCH;
              end else begin
                state <= DATA;
              end
            end
          end
          STRETCH: begin
            if (!rx_valid || rx_ready) begin
              scl_oe <= 1'b0;
              state  <= DATA;
            end else if (stretch_cnt >= STRETCH_TIMEOUT) begin
              rx_valid        <= 1'b0;
              stretch_timeout <= 1'b1;
              scl_oe          <= 1'b0;
              state           <= DATA;
            end else if (stretch_cnt != '1) begin
              stretch_cnt <= stretch_cnt + 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_slave_receiver.sv
// Directed bench for i2c_slave_receiver: a bit-banged open-drain master plus a
// negedge monitor; each scenario task checks its own expected values.
module tb_i2c_slave_receiver;

  localparam int Q = 8;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       scl_m = 1'b1;
  logic       sda_m = 1'b1;
  logic       rx_ready = 1'b0;
  logic       scl_in, sda_in;
  logic       scl_oe, sda_oe, rx_valid, rx_first;
  logic       start_seen, stop_seen, stretch_timeout, busy;
  logic [7:0] rx_data;

  int total = 0;
  int bad = 0;

  assign scl_in = scl_m & ~scl_oe;
  assign sda_in = sda_m & ~sda_oe;

  i2c_slave_receiver #(
    .ADDRESS         (7'h50),
    .SYNC_STAGES     (2),
    .STRETCH_TIMEOUT (11'd100)
  ) dut (
    .clock           (clock),
    .reset           (reset),
    .scl_in          (scl_in),
    .sda_in          (sda_in),
    .scl_oe          (scl_oe),
    .sda_oe          (sda_oe),
    .rx_data         (rx_data),
    .rx_valid        (rx_valid),
    .rx_ready        (rx_ready),
    .rx_first        (rx_first),
    .start_seen      (start_seen),
    .stop_seen       (stop_seen),
    .stretch_timeout (stretch_timeout),
    .busy            (busy)
  );

  always #5 clock = ~clock;

  // Monitor: cumulative counters, scenario tasks compare deltas
  int         n_start = 0, n_stop = 0, n_to = 0;
  int         c_sda = 0, c_scl = 0, c_rxv = 0, c_busy = 0;
  int         run = 0, last_run = 0;
  logic       rxv_at_to = 1'b1;
  logic       prev_rxv = 1'b0;
  logic [8:0] bytes[$];

  always @(negedge clock) begin
    if (start_seen) n_start++;
    if (stop_seen) n_stop++;
    if (stretch_timeout) begin
      n_to++;
      rxv_at_to = rx_valid;
    end
    if (sda_oe) c_sda++;
    if (scl_oe) c_scl++;
    if (rx_valid) c_rxv++;
    if (busy) c_busy++;
    if (scl_oe) run++;
    else if (run != 0) begin
      last_run = run;
      run = 0;
    end
    if (rx_valid && !prev_rxv) bytes.push_back({rx_first, rx_data});
    prev_rxv = rx_valid;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic scl_high();
    int n;
    n = 0;
    scl_m = 1'b1;
    while (scl_in !== 1'b1 && n < 5000) begin
      tick(1);
      n++;
    end
    if (n >= 5000) begin
      total++;
      bad++;
      $display("FAIL scl_release_wait: scl_in=%b required 1", scl_in);
    end
  endtask

  task automatic bus_start();
    sda_m = 1'b1;
    tick(Q);
    scl_high();
    tick(Q);
    sda_m = 1'b0;
    tick(Q);
    scl_m = 1'b0;
    tick(Q);
  endtask

  task automatic bus_stop();
    sda_m = 1'b0;
    tick(Q);
    scl_high();
    tick(Q);
    sda_m = 1'b1;
    tick(Q);
  endtask

  task automatic send_bit(input logic b);
    sda_m = b;
    tick(Q);
    scl_high();
    tick(Q);
    scl_m = 1'b0;
    tick(Q);
  endtask

  task automatic ack_clock(output logic ack);
    sda_m = 1'b1;
    tick(Q);
    scl_high();
    tick(Q / 2);
    ack = ~sda_in;
    tick(Q / 2);
    scl_m = 1'b0;
    tick(Q);
  endtask

  task automatic send_byte(input logic [7:0] b, output logic ack);
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
    ack_clock(ack);
  endtask

  task automatic test_reset();
    logic [15:0] obs;
    reset = 1'b1;
    tick(3);
    obs = {scl_oe, sda_oe, rx_valid, rx_first, start_seen, stop_seen,
           stretch_timeout, busy, rx_data};
    total++;
    if (obs !== 16'h0000) begin
      bad++;
      $display("FAIL reset_outputs: got %h want 0000", obs);
    end
    reset = 1'b0;
    tick(Q);
  endtask

  task automatic test_basic_write();
    int s0, p0, b0, sc0;
    logic a0, a1, a2;
    logic [8:0] got;
    rx_ready = 1'b1;
    s0 = n_start; p0 = n_stop; b0 = bytes.size(); sc0 = c_scl;
    bus_start();
    send_byte(8'hA0, a0);
    total++;
    if (busy !== 1'b1) begin bad++; $display("FAIL basic_busy: got %b want 1", busy); end
    send_byte(8'hA5, a1);
    send_byte(8'h3C, a2);
    bus_stop();
    tick(Q);
    total++;
    if ({a0, a1, a2} !== 3'b111) begin bad++; $display("FAIL basic_acks: got %b want 111", {a0, a1, a2}); end
    total++;
    if (n_start - s0 != 1) begin bad++; $display("FAIL basic_start: got %0d want 1", n_start - s0); end
    total++;
    if (n_stop - p0 != 1) begin bad++; $display("FAIL basic_stop: got %0d want 1", n_stop - p0); end
    total++;
    if (bytes.size() - b0 != 2) begin bad++; $display("FAIL basic_count: got %0d want 2", bytes.size() - b0); end
    got = (bytes.size() > b0) ? bytes[b0] : 9'hxxx;
    total++;
    if (got !== {1'b1, 8'hA5}) begin bad++; $display("FAIL basic_byte0: got %h want 1a5", got); end
    got = (bytes.size() > b0 + 1) ? bytes[b0 + 1] : 9'hxxx;
    total++;
    if (got !== {1'b0, 8'h3C}) begin bad++; $display("FAIL basic_byte1: got %h want 03c", got); end
    total++;
    if (c_scl - sc0 != 0) begin bad++; $display("FAIL basic_no_stretch: got %0d want 0", c_scl - sc0); end
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL basic_busy_after_stop: got %b want 0", busy); end
  endtask

  task automatic test_wrong_addr();
    int sd0, rv0, by0;
    logic a, d;
    sd0 = c_sda; rv0 = c_rxv; by0 = c_busy;
    bus_start();
    send_byte(8'hA2, a);
    send_byte(8'hFF, d);
    bus_stop();
    total++;
    if ({a, d} !== 2'b00) begin bad++; $display("FAIL wrong_addr_acks: got %b want 00", {a, d}); end
    total++;
    if (c_sda - sd0 != 0) begin bad++; $display("FAIL wrong_addr_sda_oe: got %0d want 0", c_sda - sd0); end
    total++;
    if (c_rxv - rv0 != 0) begin bad++; $display("FAIL wrong_addr_rx_valid: got %0d want 0", c_rxv - rv0); end
    total++;
    if (c_busy - by0 != 0) begin bad++; $display("FAIL wrong_addr_busy: got %0d want 0", c_busy - by0); end
  endtask

  task automatic test_read_nack();
    int sd0, rv0;
    logic a;
    sd0 = c_sda; rv0 = c_rxv;
    bus_start();
    send_byte(8'hA1, a);
    bus_stop();
    total++;
    if (a !== 1'b0) begin bad++; $display("FAIL read_nack_ack: got %b want 0", a); end
    total++;
    if (c_sda - sd0 != 0) begin bad++; $display("FAIL read_nack_sda_oe: got %0d want 0", c_sda - sd0); end
    total++;
    if (c_rxv - rv0 != 0) begin bad++; $display("FAIL read_nack_rx_valid: got %0d want 0", c_rxv - rv0); end
  endtask

  task automatic test_stretch();
    int t0;
    logic a, d, d2;
    logic [8:0] got;
    rx_ready = 1'b0;
    t0 = n_to;
    bus_start();
    send_byte(8'hA0, a);
    send_byte(8'h5A, d);
    tick(4);
    total++;
    if ({a, d} !== 2'b11) begin bad++; $display("FAIL stretch_acks: got %b want 11", {a, d}); end
    total++;
    if ({scl_oe, rx_valid, rx_first, rx_data} !== {3'b111, 8'h5A}) begin
      bad++;
      $display("FAIL stretch_hold: got oe=%b v=%b f=%b d=%h want 1 1 1 5a", scl_oe, rx_valid, rx_first, rx_data);
    end
    tick(50);
    total++;
    if (scl_oe !== 1'b1) begin bad++; $display("FAIL stretch_still_held: got %b want 1", scl_oe); end
    rx_ready = 1'b1;
    @(posedge clock);
    @(negedge clock);
    total++;
    if ({rx_valid, scl_oe} !== 2'b00) begin bad++; $display("FAIL stretch_release: got v=%b oe=%b want 0 0", rx_valid, scl_oe); end
    tick(1);
    send_byte(8'h81, d2);
    bus_stop();
    got = (bytes.size() > 0) ? bytes[bytes.size() - 1] : 9'hxxx;
    total++;
    if (d2 !== 1'b1) begin bad++; $display("FAIL stretch_next_ack: got %b want 1", d2); end
    total++;
    if (got !== {1'b0, 8'h81}) begin bad++; $display("FAIL stretch_next_byte: got %h want 081", got); end
    total++;
    if (n_to - t0 != 0) begin bad++; $display("FAIL stretch_no_timeout: got %0d want 0", n_to - t0); end
  endtask

  task automatic test_timeout();
    int t0, n;
    logic a, d;
    rx_ready = 1'b0;
    t0 = n_to;
    bus_start();
    send_byte(8'hA0, a);
    send_byte(8'h33, d);
    n = 0;
    while (n_to == t0 && n < 1000) begin
      tick(1);
      n++;
    end
    tick(2);
    total++;
    if (n_to - t0 != 1) begin bad++; $display("FAIL timeout_pulse: got %0d want 1", n_to - t0); end
    total++;
    if (last_run != 101) begin bad++; $display("FAIL timeout_stretch_len: got %0d want 101", last_run); end
    total++;
    if (rxv_at_to !== 1'b0) begin bad++; $display("FAIL timeout_rx_valid: got %b want 0", rxv_at_to); end
    total++;
    if ({scl_oe, rx_valid} !== 2'b00) begin bad++; $display("FAIL timeout_released: got oe=%b v=%b want 0 0", scl_oe, rx_valid); end
    rx_ready = 1'b1;
    bus_stop();
  endtask

  task automatic test_restart();
    int s0, b0;
    logic a0, a1, d;
    logic [8:0] got;
    rx_ready = 1'b1;
    s0 = n_start; b0 = bytes.size();
    bus_start();
    send_byte(8'hA0, a0);
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
    bus_start();
    send_byte(8'hA0, a1);
    send_byte(8'h6C, d);
    bus_stop();
    total++;
    if (n_start - s0 != 2) begin bad++; $display("FAIL restart_starts: got %0d want 2", n_start - s0); end
    total++;
    if ({a0, a1, d} !== 3'b111) begin bad++; $display("FAIL restart_acks: got %b want 111", {a0, a1, d}); end
    got = (bytes.size() == b0 + 1) ? bytes[b0] : 9'hxxx;
    total++;
    if (got !== {1'b1, 8'h6C}) begin bad++; $display("FAIL restart_byte: got %h want 16c (count %0d)", got, bytes.size() - b0); end
  endtask

  task automatic test_reset_in_ack();
    int p0;
    logic [7:0] addr;
    addr = 8'hA0;
    bus_start();
    for (int i = 7; i >= 0; i--) send_bit(addr[i]);
    sda_m = 1'b1;
    tick(Q);
    scl_high();
    tick(2);
    total++;
    if ({sda_oe, busy} !== 2'b11) begin bad++; $display("FAIL reset_ack_pre: got oe=%b busy=%b want 1 1", sda_oe, busy); end
    reset = 1'b1;
    @(posedge clock);
    @(negedge clock);
    total++;
    if ({sda_oe, scl_oe, busy} !== 3'b000) begin
      bad++;
      $display("FAIL reset_ack_release: got sda_oe=%b scl_oe=%b busy=%b want 0 0 0", sda_oe, scl_oe, busy);
    end
    reset = 1'b0;
    tick(Q);
    scl_m = 1'b0;
    tick(Q);
    p0 = n_stop;
    bus_stop();
    tick(2);
    total++;
    if (n_stop - p0 != 1) begin bad++; $display("FAIL reset_ack_stop: got %0d want 1", n_stop - p0); end
  endtask

  initial begin
    #500us;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic_write();
    test_wrong_addr();
    test_read_nack();
    test_stretch();
    test_timeout();
    test_restart();
    test_reset_in_ack();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
